// File: rtl/rv32i_pkg.sv
// Shared RV32I core parameters.
package rv32i_pkg;
    localparam int PC_WIDTH = 32;
endpackage

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding req/gnt/rvalid read, 2-entry buffer to decode; fetch-to-instr_valid 3 cycles minimum.
// Backpressure: no new request unless buffered + in-flight < 2; redirect flushes the buffer and drops the in-flight response.
module ifetch #(
    parameter int PC_WIDTH   = rv32i_pkg::PC_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                fetch_en,
    input  logic                redirect,
    output logic                pc_advance,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                instr_valid,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] instr_pc,
    output logic                instr_err,
    input  logic                instr_ready
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [1:0]  DEPTH = FIFO_DEPTH[1:0];

    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
        logic                err;
    } entry_t;

    state_t     state, state_n;
    logic       discard, discard_n;
    logic [1:0] count;
    logic       rd_ptr, wr_ptr;
    entry_t     mem [2];
    entry_t     push_dat;
    logic       space, fetch_ok, issue, misalign, rsp, push, do_push, pop;

    always_comb begin
        space    = (count + {1'b0, state != IDLE}) < DEPTH;
        fetch_ok = (state == IDLE) && fetch_en && space && !redirect;
        issue    = fetch_ok && (pc[1:0] == 2'b00);
        misalign = fetch_ok && (pc[1:0] != 2'b00);
        rsp      = (state == WAIT_RSP) && imem_rvalid;
        // A response coinciding with redirect belongs to the old stream.
        push     = !redirect && (misalign || (rsp && !discard));
        pop      = instr_valid && instr_ready;
        do_push  = push && ((count != DEPTH) || pop);
        push_dat = misalign ? entry_t'{NOP, pc, 1'b1}
                            : entry_t'{imem_rdata, imem_addr, 1'b0};
        pc_advance = rst && (misalign ||
                     ((state == WAIT_GNT) && imem_gnt && !redirect));
    end

    always_comb begin
        state_n   = state;
        discard_n = discard;
        unique case (state)
            IDLE: begin
                if (issue) state_n = WAIT_GNT;
            end
            WAIT_GNT: begin
                if (imem_gnt) state_n = WAIT_RSP;
                if (redirect) discard_n = 1'b1;
            end
            WAIT_RSP: begin
                if (imem_rvalid) begin
                    state_n   = IDLE;
                    discard_n = 1'b0;
                end else if (redirect) begin
                    discard_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            discard   <= 1'b0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state   <= state_n;
            discard <= discard_n;
            // imem_addr is held past gnt so it tags the returning data.
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= pc;
            end else if ((state == WAIT_GNT) && imem_gnt) begin
                imem_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) mem[i] <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, pop};
        end
    end

    assign instr_valid = (count != 2'd0);
    assign instr       = mem[rd_ptr].instr;
    assign instr_pc    = mem[rd_ptr].pc;
    assign instr_err   = mem[rd_ptr].err;

    a_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (state == WAIT_RSP));
endmodule
